// File: rtl/tone_player.sv
// tone_player: queued square-wave note player driving the piano buzzer pin.
// Notes of (half-period, duration) are accepted into a small FIFO and played
// one after another. A half-period of 0 is a rest; a duration of 0 skips the
// entry. Defining the macro TONE_GAP_EN adds a silent articulation gap of
// GAP_TICKS ticks after every played note.
module tone_player #(
    parameter int HP_W      = 18,
    parameter int DUR_W     = 12,
    parameter int TICK_DIV  = 100000,
    parameter int DEPTH     = 4,
    parameter int GAP_TICKS = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic [HP_W-1:0]              note_half,
    input  logic [DUR_W-1:0]             note_dur,
    input  logic                         stop,
    output logic                         speaker,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

`ifdef TONE_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1} state_t;
    // The gap length only matters when the gap feature is built in.
    localparam int unused_gap_ticks = GAP_TICKS;
`endif

    // FIFO storage and bookkeeping
    logic [HP_W-1:0]  mem_half_r [DEPTH];
    logic [DUR_W-1:0] mem_dur_r  [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [HP_W-1:0]  head_half_s;
    logic [DUR_W-1:0] head_dur_s;

    // Player state and counters
    state_t           state_r;
    state_t           state_nxt_s;
    state_t           fsm_nxt_s;
    logic             fsm_pop_s;
    logic             play_done_s;
    logic [HP_W-1:0]  cur_half_r;
    logic [DUR_W-1:0] cur_dur_r;
    logic [HP_W-1:0]  phase_r;
    logic [PW-1:0]    presc_r;
    logic [DUR_W-1:0] dur_cnt_r;
    logic             speaker_r;
    logic             tick_wrap_s;

    assign full_s      = (count_r == LEVEL_FULL);
    assign empty_s     = (count_r == {LW{1'b0}});
    assign note_ready  = !full_s && !stop;
    assign push_s      = note_valid && note_ready;
    assign head_half_s = mem_half_r[rd_ptr_r];
    assign head_dur_s  = mem_dur_r[rd_ptr_r];
    assign tick_wrap_s = (presc_r == PRESC_LAST);

    assign speaker = speaker_r;
    assign level   = count_r;
    assign busy    = (state_r != IDLE) || !empty_s;

    // FIFO entry storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_half_r[i] <= {HP_W{1'b0}};
                mem_dur_r[i]  <= {DUR_W{1'b0}};
            end
        end else if (push_s) begin
            mem_half_r[wr_ptr_r] <= note_half;
            mem_dur_r[wr_ptr_r]  <= note_dur;
        end else begin
            mem_half_r[wr_ptr_r] <= mem_half_r[wr_ptr_r];
            mem_dur_r[wr_ptr_r]  <= mem_dur_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; stop flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else if (stop) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Player state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: pop in IDLE, leave PLAY/GAP on their last tick; stop overrides.
    always_comb begin
        fsm_nxt_s   = state_r;
        fsm_pop_s   = 1'b0;
        play_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    fsm_pop_s = 1'b1;
                    if (head_dur_s != {DUR_W{1'b0}}) begin
                        fsm_nxt_s = PLAY;
                    end else begin
                        fsm_nxt_s = IDLE;
                    end
                end else begin
                    fsm_nxt_s = IDLE;
                end
            end
            PLAY: begin
                if (tick_wrap_s && (dur_cnt_r == cur_dur_r - DUR_W'(1))) begin
                    play_done_s = 1'b1;
`ifdef TONE_GAP_EN
                    fsm_nxt_s   = GAP;
`else
                    fsm_nxt_s   = IDLE;
`endif
                end else begin
                    fsm_nxt_s = PLAY;
                end
            end
`ifdef TONE_GAP_EN
            GAP: begin
                if (tick_wrap_s && (dur_cnt_r == GAP_LAST)) begin
                    fsm_nxt_s = IDLE;
                end else begin
                    fsm_nxt_s = GAP;
                end
            end
`endif
            default: begin
                fsm_nxt_s = IDLE;
            end
        endcase
        state_nxt_s = stop ? IDLE : fsm_nxt_s;
        pop_s       = fsm_pop_s && !stop;
    end

    // Note datapath: load on pop, run phase/tick/duration counters, drive the speaker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_half_r <= {HP_W{1'b0}};
            cur_dur_r  <= {DUR_W{1'b0}};
            phase_r    <= {HP_W{1'b0}};
            presc_r    <= {PW{1'b0}};
            dur_cnt_r  <= {DUR_W{1'b0}};
            speaker_r  <= 1'b0;
        end else if (stop) begin
            phase_r    <= {HP_W{1'b0}};
            presc_r    <= {PW{1'b0}};
            dur_cnt_r  <= {DUR_W{1'b0}};
            speaker_r  <= 1'b0;
        end else if (pop_s) begin
            cur_half_r <= head_half_s;
            cur_dur_r  <= head_dur_s;
            phase_r    <= {HP_W{1'b0}};
            presc_r    <= {PW{1'b0}};
            dur_cnt_r  <= {DUR_W{1'b0}};
            speaker_r  <= 1'b0;
        end else if (state_r == PLAY) begin
            if (play_done_s) begin
                // Silence from this edge; counters restart for the gap, if any.
                phase_r   <= {HP_W{1'b0}};
                presc_r   <= {PW{1'b0}};
                dur_cnt_r <= {DUR_W{1'b0}};
                speaker_r <= 1'b0;
            end else begin
                if (tick_wrap_s) begin
                    presc_r   <= {PW{1'b0}};
                    dur_cnt_r <= dur_cnt_r + DUR_W'(1);
                end else begin
                    presc_r   <= presc_r + PW'(1);
                end
                if (phase_r == cur_half_r) begin
                    phase_r <= {HP_W{1'b0}};
                    // A rest (half-period 0) keeps the pin low.
                    if (cur_half_r != {HP_W{1'b0}}) begin
                        speaker_r <= ~speaker_r;
                    end else begin
                        speaker_r <= 1'b0;
                    end
                end else begin
                    phase_r <= phase_r + HP_W'(1);
                end
            end
`ifdef TONE_GAP_EN
        end else if (state_r == GAP) begin
            speaker_r <= 1'b0;
            if (tick_wrap_s) begin
                presc_r <= {PW{1'b0}};
                if (dur_cnt_r == GAP_LAST) begin
                    dur_cnt_r <= {DUR_W{1'b0}};
                end else begin
                    dur_cnt_r <= dur_cnt_r + DUR_W'(1);
                end
            end else begin
                presc_r <= presc_r + PW'(1);
            end
`endif
        end else begin
            speaker_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed bench for tone_player with a behavioural model.
// The model keeps the note queue and derives the speaker level from the
// elapsed cycles of the current note; a compare process checks every cycle.
// Build with TONE_GAP_EN defined to exercise the articulation gap.
module tb_tone_player;

    localparam int HP_W      = 18;
    localparam int DUR_W     = 12;
    localparam int TICK_DIV  = 10;
    localparam int DEPTH     = 4;
    localparam int GAP_TICKS = 2;
`ifdef TONE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam int GAP_CYC = GAP_EN ? GAP_TICKS * TICK_DIV : 0;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       note_valid;
    logic                       note_ready;
    logic [HP_W-1:0]            note_half;
    logic [DUR_W-1:0]           note_dur;
    logic                       stop;
    logic                       speaker;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] level;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    tone_player #(
        .HP_W(HP_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV),
        .DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
        .note_half(note_half), .note_dur(note_dur), .stop(stop),
        .speaker(speaker), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int half; int dur; } ent_t;
    ent_t q[$];
    ent_t cur;
    int   mode = 0;   // 0 idle, 1 playing, 2 gap
    int   k = 0;      // cycles elapsed in current play/gap
    int   m_speaker = 0;
    bit   m_acc;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || stop) begin
                q.delete();
                mode = 0;
                k = 0;
                m_speaker = 0;
            end else begin
                m_acc = note_valid && (q.size() < DEPTH);
                if (mode == 0) begin
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        if (cur.dur != 0) begin
                            mode = 1;
                            k = 0;
                        end
                    end
                end else if (mode == 1) begin
                    k++;
                    if (k == cur.dur * TICK_DIV) begin
                        mode = GAP_EN ? 2 : 0;
                        k = 0;
                    end
                end else begin
                    k++;
                    if (k == GAP_TICKS * TICK_DIV) begin
                        mode = 0;
                        k = 0;
                    end
                end
                if (m_acc) q.push_back('{int'(note_half), int'(note_dur)});
                m_speaker = (mode == 1 && cur.half != 0) ? (k / (cur.half + 1)) % 2 : 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("speaker", int'(speaker), m_speaker);
            check("level", int'(level), q.size());
            check("busy", int'(busy), (mode != 0 || q.size() != 0) ? 1 : 0);
            check("note_ready", int'(note_ready), (q.size() < DEPTH && !stop) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Offer one entry and hold it until accepted; reports edges taken.
    task automatic push_note(input int half, input int dur, output int waited);
        logic acc;
        note_half  = HP_W'(half);
        note_dur   = DUR_W'(dur);
        note_valid = 1'b1;
        waited = 0;
        acc = 1'b0;
        do begin
            acc = note_ready;
            cyc();
            waited++;
        end while (!acc && waited < 300);
        if (!acc) check("push_timeout", 0, 1);
        note_valid = 1'b0;
    endtask

    int w;

    initial begin
        rst_n = 1'b0; note_valid = 1'b0; note_half = '0; note_dur = '0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("reset_speaker", int'(speaker), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_level", int'(level), 0);
        check("reset_ready", int'(note_ready), 1);
        cmp_en = 1'b1;

        // Single note {4,3}: rise at N+6, 30 cycles of play, busy low at N+31.
        push_note(4, 3, w);
        check("single_accept", w, 1);
        repeat (5) cyc();
        check("single_pre_rise", int'(speaker), 0);
        cyc();
        check("single_rise", int'(speaker), 1);
        repeat (5) cyc();
        check("single_fall", int'(speaker), 0);
        repeat (19) cyc();
        check("single_last_busy", int'(busy), 1);
        check("single_last_high", int'(speaker), 1);
        cyc();
        check("single_end_speaker", int'(speaker), 0);
        check("single_busy_fall", int'(busy), 0);
        repeat (5) cyc();

        // Queue fill behind a 60-cycle note; fifth entry waits for a pop.
        push_note(2, 6, w);
        push_note(1, 1, w);
        check("fill_first_accept", w, 1);
        push_note(3, 1, w);
        push_note(0, 1, w);
        push_note(5, 2, w);
        check("fill_level4", int'(level), 4);
        check("fill_ready_low", int'(note_ready), 0);
        push_note(2, 1, w);
        check("fill_fifth_wait", w, 59);
        check("fill_level_after", int'(level), 4);
        repeat (120) cyc();

        // Rest {0,2}, skip {3,0}, tone {2,1}.
        push_note(0, 2, w);
        push_note(3, 0, w);
        push_note(2, 1, w);
        repeat (20) cyc();
        check("skip_level_mid", int'(level), 1);
        cyc();
        check("skip_level_empty", int'(level), 0);
        repeat (2) cyc();
        check("skip_pre_rise", int'(speaker), 0);
        cyc();
        check("skip_rise", int'(speaker), 1);
        repeat (12) cyc();

        // Full-scale half-period: never toggles within a 10-cycle note.
        push_note((1 << HP_W) - 1, 1, w);
        repeat (14) cyc();

        // Stop during the second of three queued notes.
        push_note(3, 2, w);
        push_note(2, 2, w);
        push_note(4, 2, w);
        repeat (28) cyc();
        check("stop_pre_level", int'(level), 1);
        check("stop_pre_busy", int'(busy), 1);
        stop = 1'b1; note_valid = 1'b1; note_half = HP_W'(5); note_dur = DUR_W'(1);
        #1;
        check("stop_ready_low", int'(note_ready), 0);
        cyc();
        stop = 1'b0; note_valid = 1'b0;
        #1;
        check("stop_speaker", int'(speaker), 0);
        check("stop_level", int'(level), 0);
        check("stop_busy", int'(busy), 0);
        repeat (10) cyc();

        // Asynchronous reset in the middle of a high phase.
        push_note(4, 3, w);
        repeat (7) cyc();
        check("rst_pre_speaker", int'(speaker), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_speaker", int'(speaker), 0);
        check("rst_async_level", int'(level), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst_rel_speaker", int'(speaker), 0);
        check("rst_rel_busy", int'(busy), 0);
        check("rst_rel_level", int'(level), 0);
        check("rst_rel_ready", int'(note_ready), 1);
        repeat (5) cyc();

        // Two {4,1} notes: second rise at N+17, plus the gap when built in.
        push_note(4, 1, w);
        push_note(4, 1, w);
        repeat (9) cyc();
        check("gap_play_busy", int'(busy), 1);
        cyc();
        check("gap_first_end", int'(speaker), 0);
        repeat (5 + GAP_CYC) cyc();
        check("gap_second_pre", int'(speaker), 0);
        check("gap_second_busy", int'(busy), 1);
        cyc();
        check("gap_second_rise", int'(speaker), 1);
        repeat (20) cyc();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_player.md
# tone_player

Queued note player that drives the piano buzzer pin. Accepts (half-period, duration) note entries through a valid/ready port into a small FIFO, then plays each entry for its duration as a 50 % square wave before moving to the next. It is the parametrised successor to the free-running single-tone buzzer driver, adding a note queue, timed durations, rests, a stop/flush control and an optional articulation gap. It sits between the song/keyboard sequencer and the speaker output pin.

## Interface
- HP_W, 18: width of the half-period field and counter.
- DUR_W, 12: width of the duration field, in ticks.
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz); ≥2.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- GAP_TICKS, 20: articulation gap length in ticks; used only with TONE_GAP_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note_valid  in  1  producer offers an entry.
- note_ready  out  1  = !full && !stop.
- note_half  in  HP_W  speaker toggles every note_half+1 clk cycles; 0 = rest.
- note_dur  in  DUR_W  note length in ticks; 0 = skip.
- stop  in  1  synchronous flush and silence.
- speaker  out  1  registered buzzer drive.
- busy  out  1  high when state != IDLE or FIFO non-empty.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Push on rising clk when note_valid && note_ready; entry is {note_half, note_dur}. No push/pop bypass: a full FIFO stays not-ready even in a cycle where it pops.
- Required states: IDLE, PLAY, GAP (GAP exists only with TONE_GAP_EN).
- IDLE: if FIFO non-empty, pop head into cur_half/cur_dur, clear the phase counter, pwm, tick prescaler and duration counter, then enter PLAY. If the popped cur_dur is 0, stay in IDLE, so the entry is consumed in one cycle.
- PLAY, tone: the phase counter counts 0..cur_half. At equality, pwm toggles and the counter clears. speaker = pwm.
- PLAY, rest: when cur_half = 0, speaker is held 0.
- PLAY, duration: the prescaler counts 0..TICK_DIV-1; each wrap increments the duration counter. When the duration counter reaches cur_dur (cur_dur·TICK_DIV cycles after entering PLAY), leave PLAY. The next state is GAP if enabled, else IDLE. speaker is forced 0 from that edge.
- speaker is 0 whenever the state is not PLAY.
- stop has highest priority. On the next edge the FIFO is emptied, level = 0, state = IDLE and speaker = 0. Pushes are blocked because ready is low while stop is asserted.
- Counters use equality compare, so there is no overflow at any width. Full-scale note_half = 2^HP_W−1 is legal.

## Timing
- Reset values: speaker 0, busy 0, level 0, note_ready 1, state IDLE, all counters 0. Reset mid-note silences speaker immediately (asynchronous) and discards the FIFO.
- Push accepted at edge N: level increments at N, pop at edge N+1, PLAY from N+1.
- First speaker rise at edge N+1+(note_half+1); period thereafter 2·(note_half+1) cycles.
- PLAY lasts exactly note_dur·TICK_DIV cycles. Back-to-back notes have exactly 1 IDLE cycle between them (speaker 0), plus GAP_TICKS·TICK_DIV cycles when the gap is enabled.
- level decrements on the pop edge. A simultaneous push and pop leaves level unchanged.
- busy falls on the edge that enters IDLE with the FIFO empty.

## Configuration
- TONE_GAP_EN defined: after every note with non-zero duration, GAP holds speaker 0 for GAP_TICKS ticks (prescaler restarted), then goes to IDLE. busy stays high through GAP. stop aborts GAP.
- TONE_GAP_EN undefined: GAP state and its counter logic are absent; PLAY goes directly to IDLE; GAP_TICKS is ignored.

## Test plan
Benches use TICK_DIV=10, DEPTH=4.
- Single note: push {half=4, dur=3} at edge N -> speaker rises at N+6, toggles every 5 cycles, exactly 30 cycles of PLAY, then 0; busy falls at N+31.
- Queue fill: push 5 entries back-to-back with consumer stalled by a long first note -> note_ready low after level=4, 5th held until a pop, level sequence correct, notes play in order with 1-cycle gaps.
- Rest and skip: push {0,2} then {3,0} then {2,1} -> speaker 0 for 20 cycles, skip entry consumed in 1 cycle, then the half=2 tone plays for 10 cycles.
- Stop mid-note: assert stop for 1 cycle during the second of three queued notes -> next edge speaker 0, level 0, IDLE; note_ready low during stop; a push presented during stop is not accepted.
- Async reset: drop rst_n mid-PLAY between edges -> speaker 0 immediately, and all outputs at reset values after release.
- With TONE_GAP_EN, GAP_TICKS=2: two {4,1} notes -> 20 silent cycles plus the 1 IDLE cycle between the notes.
